// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag register layout and FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDC = 4'd1,
      OP_SUB  = 4'd2,
      OP_SUBC = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_MUL  = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } alu_flags_t;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } alu_state_e;

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// done and product are combinational on the final step so the caller can latch on that edge.
module seq_mul_unit #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic [WIDTH:0]     partial;
   logic [2*WIDTH-1:0] prod_step;

   // Upper half accumulates; multiplier bits shift out of the lower half.
   always_comb begin
      partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_step = {partial, prod_q[WIDTH-1:1]};
   end

   assign done    = busy_q && (cnt_q == CW'(1));
   assign product = prod_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (start) begin
         mcand_q <= a;
         prod_q  <= {{WIDTH{1'b0}}, b};
         cnt_q   <= CW'(WIDTH);
         busy_q  <= 1'b1;
      end else if (busy_q) begin
         prod_q <= prod_step;
         cnt_q  <= cnt_q - CW'(1);
         if (cnt_q == CW'(1))
            busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with persistent Z/C/N/V flags and an iterative multiplier.
//  state   | meaning
//  IDLE    | accepting ops; non-MUL results registered on the accept edge
//  MUL_RUN | multiplier stepping, in_ready low, in_valid ignored
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flags_clr,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
   output logic             flag_v
);
   localparam int W = WIDTH;

   alu_state_e         state_q, state_d;
   alu_flags_t         flags_q;
   logic               accept, is_mul, mul_start, mul_done, mul_fin, alu_fin;
   logic [2*W-1:0]     mul_prod;
   logic [W:0]         wide;
   logic [W-1:0]       alu_r;
   logic               alu_c, alu_v, alu_upd, cin;

   assign in_ready  = rst_n && (state_q == IDLE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = MUL_EN && (opcode == OP_MUL);
   assign mul_start = accept && is_mul;
   assign mul_fin   = (state_q == MUL_RUN) && mul_done;
   assign alu_fin   = accept && !is_mul;
   // flags_q already holds the previous op's carry, so ADD->ADDC chains need no bubble.
   assign cin       = flags_q.c;

   seq_mul_unit #(.WIDTH(W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_comb begin
      wide    = '0;
      alu_r   = '0;
      alu_c   = flags_q.c;
      alu_v   = flags_q.v;
      alu_upd = 1'b1;
      case (opcode)
         OP_ADD, OP_ADDC: begin
            wide  = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, (opcode == OP_ADDC) & cin};
            alu_r = wide[W-1:0];
            alu_c = wide[W];
            alu_v = (op_a[W-1] == op_b[W-1]) && (alu_r[W-1] != op_a[W-1]);
         end
         OP_SUB, OP_SUBC: begin
            wide  = {1'b0, op_a} - {1'b0, op_b} - {{W{1'b0}}, (opcode == OP_SUBC) & cin};
            alu_r = wide[W-1:0];
            alu_c = wide[W];
            alu_v = (op_a[W-1] != op_b[W-1]) && (alu_r[W-1] != op_a[W-1]);
         end
         OP_AND: alu_r = op_a & op_b;
         OP_OR:  alu_r = op_a | op_b;
         OP_XOR: alu_r = op_a ^ op_b;
         OP_NOT: alu_r = ~op_a;
         OP_SHL: begin
            alu_r = {op_a[W-2:0], 1'b0};
            alu_c = op_a[W-1];
         end
         OP_SHR: begin
            alu_r = {1'b0, op_a[W-1:1]};
            alu_c = op_a[0];
         end
         default: alu_upd = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mul_start) state_d = MUL_RUN;
         MUL_RUN: if (mul_done)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         flags_q   <= '0;
      end else begin
         state_q   <= state_d;
         out_valid <= 1'b0;
         if (mul_fin) begin
            out_valid <= 1'b1;
            result    <= mul_prod[W-1:0];
            result_hi <= mul_prod[2*W-1:W];
            flags_q   <= alu_flags_t'{z: (mul_prod == '0), c: (mul_prod[2*W-1:W] != '0),
                                      n: mul_prod[W-1],  v: (mul_prod[2*W-1:W] != '0)};
         end else if (alu_fin) begin
            out_valid <= 1'b1;
            result    <= alu_r;
            result_hi <= '0;
            if (alu_upd)
               flags_q <= alu_flags_t'{z: (alu_r == '0), c: alu_c, n: alu_r[W-1], v: alu_v};
         end else if (flags_clr) begin
            flags_q <= '0;
         end
      end
   end

   assign flag_z = flags_q.z;
   assign flag_c = flags_q.c;
   assign flag_n = flags_q.n;
   assign flag_v = flags_q.v;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): directed vectors push expectations, a monitor checks each out_valid.
module tb_seq_alu;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [7:0] op_a, op_b;
   logic       flags_clr;
   logic       out_valid;
   logic [7:0] result, result_hi;
   logic       flag_z, flag_c, flag_n, flag_v;
   logic [3:0] flags;

   typedef struct {
      logic [7:0] r;
      logic [7:0] h;
      logic [3:0] f;
      int         lat;
      int         cyc;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .op_a      (op_a),
      .op_b      (op_b),
      .flags_clr (flags_clr),
      .out_valid (out_valid),
      .result    (result),
      .result_hi (result_hi),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_n    (flag_n),
      .flag_v    (flag_v)
   );

   assign flags = {flag_z, flag_c, flag_n, flag_v};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out_valid: got result=%02h hi=%02h, required no output", result, result_hi);
         end else begin
            mon_e = sb.pop_front();
            if ({result, result_hi, flags} !== {mon_e.r, mon_e.h, mon_e.f} || (cyc - mon_e.cyc) != mon_e.lat) begin
               n_bad++;
               $display("FAIL %s: got r=%02h hi=%02h zcnv=%04b lat=%0d, required r=%02h hi=%02h zcnv=%04b lat=%0d",
                        mon_e.name, result, result_hi, flags, cyc - mon_e.cyc,
                        mon_e.r, mon_e.h, mon_e.f, mon_e.lat);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic send(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [7:0] eh, input logic [3:0] ef,
                       input int lat, input bit push, input bit clr);
      exp_t e;
      bit   got;
      got       = 1'b0;
      in_valid  = 1'b1;
      opcode    = op;
      op_a      = a;
      op_b      = b;
      flags_clr = clr;
      for (int t = 0; t < 40 && !got; t++) begin
         if (in_ready) got = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      flags_clr = 1'b0;
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_accept_timeout: got in_ready=0, required 1 within 40 cycles", nm);
      end else if (push) begin
         e.r = er; e.h = eh; e.f = ef; e.lat = lat; e.cyc = cyc; e.name = nm;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required completion before 200000 time units");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; opcode = '0; op_a = '0; op_b = '0; flags_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", result, 0);
      chk("rst_result_hi", result_hi, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flags", flags, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      send("add_ff_01",  4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 0, 1, 0);
      send("addc_fwd",   4'd1, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 0, 1, 0);
      send("sub_80_01",  4'd2, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001, 0, 1, 0);
      send("sub_01_02",  4'd2, 8'h01, 8'h02, 8'hFF, 8'h00, 4'b0110, 0, 1, 0);
      idle(1);

      send("mul_ff_ff",  4'd10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0101, 8, 1, 0);
      in_valid = 1'b1; opcode = 4'd0; op_a = 8'h01; op_b = 8'h01;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("mul_busy_in_ready_%0d", i), in_ready, 0);
         @(posedge clk);
         #1;
      end
      chk("mul_done_in_ready", in_ready, 1);
      in_valid = 1'b0;
      idle(2);

      send("and_f0_3c",  4'd4, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0101, 0, 1, 0);
      send("or_f0_3c",   4'd5, 8'hF0, 8'h3C, 8'hFC, 8'h00, 4'b0111, 0, 1, 0);
      send("xor_f0_3c",  4'd6, 8'hF0, 8'h3C, 8'hCC, 8'h00, 4'b0111, 0, 1, 0);
      send("shl_f0",     4'd8, 8'hF0, 8'h3C, 8'hE0, 8'h00, 4'b0111, 0, 1, 0);
      idle(1);

      send("reserved_12", 4'd12, 8'h55, 8'hAA, 8'h00, 8'h00, 4'b0111, 0, 1, 0);
      send("shr_01",      4'd9,  8'h01, 8'h00, 8'h00, 8'h00, 4'b1101, 0, 1, 0);
      send("not_00",      4'd7,  8'h00, 8'h00, 8'hFF, 8'h00, 4'b0111, 0, 1, 0);
      send("add_7f_01",   4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b0011, 0, 1, 0);
      send("add_ff_ff",   4'd0,  8'hFF, 8'hFF, 8'hFE, 8'h00, 4'b0110, 0, 1, 0);
      send("subc_05_02",  4'd3,  8'h05, 8'h02, 8'h02, 8'h00, 4'b0000, 0, 1, 0);
      idle(1);

      send("add_pre_clr", 4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 0, 1, 0);
      idle(1);
      flags_clr = 1'b1;
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
      chk("idle_flags_clr", flags, 0);

      send("add_with_clr", 4'd0, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1101, 0, 1, 1);
      idle(1);

      send("mul_10_10_clr", 4'd10, 8'h10, 8'h10, 8'h00, 8'h01, 4'b0101, 8, 1, 0);
      flags_clr = 1'b1;
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
      chk("mul_run_flags_clr", flags, 0);
      idle(9);

      send("mul_aborted", 4'd10, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0000, 8, 0, 0);
      idle(3);
      rst_n = 1'b0;
      #1;
      chk("abort_result_hi", result_hi, 0);
      chk("abort_flags", flags, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("abort_release_in_ready", in_ready, 1);
      idle(12);

      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
